// File: rtl/vote_tally_display_if.sv
// Ballot bus: control strobes and votes in, tally and display out.
// master drives start/close/cast/comps; slave drives segs/yes_count/passed/busy/done.
interface vote_tally_display_if #(
  parameter int N_VOTERS = 5
);
  localparam int CW = $clog2(N_VOTERS + 1);

  logic                start;
  logic                close;
  logic [N_VOTERS-1:0] cast;
  logic [N_VOTERS-1:0] comps;
  logic [6:0]          segs;
  logic [CW-1:0]       yes_count;
  logic                passed;
  logic                busy;
  logic                done;

  modport master (
    output start, close, cast, comps,
    input  segs, yes_count, passed, busy, done
  );

  modport slave (
    input  start, close, cast, comps,
    output segs, yes_count, passed, busy, done
  );
endinterface

// File: rtl/vote_tally_display.sv
// Vote tally with seven-segment result display (IDLE/COLLECT/DECIDE/SHOW).
// Ports: clk, rst (async active-high), bus (slave side of vote_tally_display_if).
module vote_tally_display #(
  parameter int N_VOTERS = 5,
  parameter int QUORUM   = 3,
  parameter int TIMEOUT  = 16,
  parameter int HOLD     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  vote_tally_display_if.slave  bus
);
  localparam int CW = $clog2(N_VOTERS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DECIDE  = 2'd2;
  localparam logic [1:0] SHOW    = 2'd3;

  localparam logic [CW-1:0] Q_MIN  = CW'(QUORUM);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD - 1);

  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [CW-1:0] popcount(
    input logic [N_VOTERS-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_VOTERS; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [6:0] digit(
    input logic [CW-1:0] v
  );
    logic [3:0] d;
    d = 4'(v);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [1:0]          state, state_n;
  logic [N_VOTERS-1:0] voted, voted_n;
  logic [N_VOTERS-1:0] yes, yes_n;
  logic [N_VOTERS-1:0] acc;
  logic [CW-1:0]       cnt, cnt_n;
  logic                pass, pass_n;
  logic [TW-1:0]       tcnt, tcnt_n;
  logic [HW-1:0]       hcnt, hcnt_n;
  logic [6:0]          segs_n;

  always_comb begin
    state_n = state;
    voted_n = voted;
    yes_n   = yes;
    acc     = '0;
    cnt_n   = cnt;
    pass_n  = pass;
    tcnt_n  = tcnt;
    hcnt_n  = hcnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = COLLECT;
          voted_n = '0;
          yes_n   = '0;
          cnt_n   = '0;
          pass_n  = 1'b0;
          tcnt_n  = '0;
        end
      end
      COLLECT: begin
        // only first vote per voter lands
        acc     = bus.cast & ~voted;
        voted_n = voted | acc;
        yes_n   = yes | (acc & bus.comps);
        cnt_n   = popcount(yes_n);
        tcnt_n  = tcnt + TW'(1);
        if ((&voted_n) || bus.close ||
            (tcnt == T_LAST))
          state_n = DECIDE;
      end
      DECIDE: begin
        pass_n  = (cnt >= Q_MIN);
        hcnt_n  = '0;
        state_n = SHOW;
      end
      SHOW: begin
        if (hcnt == H_LAST)
          state_n = IDLE;
        else
          hcnt_n = hcnt + HW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // display is decoded from next-state values so it
  // lines up with the registered tally
  always_comb begin
    segs_n = SEG_BLANK;
    case (state_n)
      COLLECT: segs_n = digit(cnt_n);
      DECIDE:  segs_n = SEG_DASH;
      SHOW:    segs_n = pass_n ? SEG_A : SEG_R;
      default: segs_n = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      voted    <= '0;
      yes      <= '0;
      cnt      <= '0;
      pass     <= 1'b0;
      tcnt     <= '0;
      hcnt     <= '0;
      bus.segs <= SEG_BLANK;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_n;
      voted    <= voted_n;
      yes      <= yes_n;
      cnt      <= cnt_n;
      pass     <= pass_n;
      tcnt     <= tcnt_n;
      hcnt     <= hcnt_n;
      bus.segs <= segs_n;
      bus.busy <= (state_n == COLLECT) ||
                  (state_n == DECIDE);
      bus.done <= (state_n == SHOW);
    end
  end

  assign bus.yes_count = cnt;
  assign bus.passed    = pass;
endmodule

// File: tb/tb_vote_tally_display.sv
// Directed bench for vote_tally_display, N_VOTERS=5 QUORUM=3
// TIMEOUT=16 HOLD=4; checks sampled 1 time unit after each rising edge.
module tb_vote_tally_display;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  vote_tally_display_if #(.N_VOTERS(5)) bus ();

  vote_tally_display #(
    .N_VOTERS(5),
    .QUORUM(3),
    .TIMEOUT(16),
    .HOLD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic       s,
    input logic       c,
    input logic [4:0] ca,
    input logic [4:0] co
  );
    bus.start = s;
    bus.close = c;
    bus.cast  = ca;
    bus.comps = co;
  endtask

  task automatic drain_show(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      step();
    end
    chk({tag, "_idle_segs"}, 32'(bus.segs), 32'h7F);
    chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 5'b0, 5'b0);
    #12;
    chk("rst_segs", 32'(bus.segs), 32'h7F);
    chk("rst_cnt", 32'(bus.yes_count), 32'd0);
    chk("rst_pass", 32'(bus.passed), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_wait", 32'(bus.busy), 32'd0);

    // all vote at once, 3 yes -> pass
    drive(1'b1, 1'b0, 5'b0, 5'b0);
    step();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_seg0", 32'(bus.segs), 32'h40);
    drive(1'b0, 1'b0, 5'b11111, 5'b10110);
    step();
    drive(1'b0, 1'b0, 5'b0, 5'b0);
    chk("t1_cnt", 32'(bus.yes_count), 32'd3);
    chk("t1_dec", 32'(bus.segs), 32'h3F);
    step();
    chk("t1_pass", 32'(bus.passed), 32'd1);
    chk("t1_segA", 32'(bus.segs), 32'h08);
    drain_show("t1");

    // repeat vote ignored, close early -> fail
    drive(1'b1, 1'b0, 5'b0, 5'b0);
    step();
    drive(1'b0, 1'b0, 5'b00001, 5'b00001);
    step();
    chk("t2_cnt1", 32'(bus.yes_count), 32'd1);
    chk("t2_seg1", 32'(bus.segs), 32'h79);
    drive(1'b0, 1'b0, 5'b00001, 5'b00000);
    step();
    chk("t2_keep", 32'(bus.yes_count), 32'd1);
    drive(1'b0, 1'b1, 5'b0, 5'b0);
    step();
    chk("t2_dec", 32'(bus.segs), 32'h3F);
    drive(1'b0, 1'b0, 5'b11111, 5'b11111);
    step();
    chk("t2_pass", 32'(bus.passed), 32'd0);
    chk("t2_segr", 32'(bus.segs), 32'h2F);
    chk("t2_ign", 32'(bus.yes_count), 32'd1);
    drain_show("t2");
    drive(1'b0, 1'b0, 5'b0, 5'b0);

    // no votes -> timeout after 16 COLLECT cycles
    drive(1'b1, 1'b0, 5'b0, 5'b0);
    step();
    drive(1'b0, 1'b0, 5'b0, 5'b0);
    for (int i = 0; i < 15; i++) step();
    chk("t3_pre", 32'(bus.segs), 32'h40);
    step();
    chk("t3_dec", 32'(bus.segs), 32'h3F);
    chk("t3_cnt", 32'(bus.yes_count), 32'd0);
    step();
    chk("t3_pass", 32'(bus.passed), 32'd0);
    drain_show("t3");

    // votes on the closing edge still count
    drive(1'b1, 1'b0, 5'b0, 5'b0);
    step();
    drive(1'b0, 1'b1, 5'b00011, 5'b00011);
    step();
    drive(1'b0, 1'b0, 5'b0, 5'b0);
    chk("t4_cnt", 32'(bus.yes_count), 32'd2);
    chk("t4_dec", 32'(bus.segs), 32'h3F);
    step();
    chk("t4_show", 32'(bus.done), 32'd1);
    chk("t4_pass", 32'(bus.passed), 32'd0);
    drain_show("t4");

    // async reset in 2nd SHOW cycle
    drive(1'b1, 1'b0, 5'b0, 5'b0);
    step();
    drive(1'b0, 1'b0, 5'b11111, 5'b11111);
    step();
    drive(1'b0, 1'b0, 5'b0, 5'b0);
    step();
    chk("t5_show", 32'(bus.passed), 32'd1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_segs", 32'(bus.segs), 32'h7F);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_pass", 32'(bus.passed), 32'd0);
    #1;
    rst = 1'b0;
    step();
    chk("t5_idle", 32'(bus.busy), 32'd0);
    drive(1'b1, 1'b0, 5'b0, 5'b0);
    step();
    drive(1'b0, 1'b0, 5'b0, 5'b0);
    chk("t5_clean", 32'(bus.yes_count), 32'd0);
    chk("t5_seg0", 32'(bus.segs), 32'h40);
    drive(1'b0, 1'b0, 5'b11111, 5'b00000);
    step();
    drive(1'b0, 1'b0, 5'b0, 5'b0);
    step();
    chk("t5_fail", 32'(bus.segs), 32'h2F);
    drain_show("t5");

    // start held high throughout
    drive(1'b1, 1'b0, 5'b0, 5'b0);
    step();
    drive(1'b1, 1'b0, 5'b11111, 5'b11111);
    step();
    chk("t6_cnt", 32'(bus.yes_count), 32'd5);
    drive(1'b1, 1'b0, 5'b0, 5'b0);
    step();
    chk("t6_segA", 32'(bus.segs), 32'h08);
    drain_show("t6");
    step();
    chk("t6_rest", 32'(bus.busy), 32'd1);
    chk("t6_seg0", 32'(bus.segs), 32'h40);
    chk("t6_cnt0", 32'(bus.yes_count), 32'd0);
    drive(1'b0, 1'b1, 5'b0, 5'b0);
    step();
    drive(1'b0, 1'b0, 5'b0, 5'b0);
    step();
    drain_show("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vote_tally_display.md
VOTE_TALLY_DISPLAY -- requirements
Module: vote_tally_display

Interface
REQ-001 Parameter N_VOTERS, default 5, number of voters, legal range 1..9.
REQ-002 Parameter QUORUM, default 3, minimum yes votes to pass, legal range 1..N_VOTERS.
REQ-003 Parameter TIMEOUT, default 16, maximum COLLECT cycles before forced close, legal range >= 1.
REQ-004 Parameter HOLD, default 4, cycles the result is shown, legal range >= 1.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  opens a ballot when the block is in IDLE.
REQ-008 close  input  1  ends COLLECT early.
REQ-009 cast  input  N_VOTERS  per-voter vote strobe.
REQ-010 comps  input  N_VOTERS  per-voter vote value, 1 = yes, sampled with cast.
REQ-011 segs  output  7  active-low seven-segment drive, segs[0]=a ... segs[6]=g.
REQ-012 yes_count  output  clog2(N_VOTERS+1)  registered yes tally.
REQ-013 passed  output  1  registered decision, 1 = yes_count >= QUORUM.
REQ-014 busy  output  1  high in COLLECT and DECIDE.
REQ-015 done  output  1  high throughout SHOW.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, DECIDE, SHOW.
- All outputs are registered.
REQ-017 IDLE SHALL behave as follows.
- segs = 0x7F (blank).
- start=1 -> COLLECT next cycle.
- On that transition, clear voted mask, yes mask, yes_count, passed and the timeout counter.
REQ-018 COLLECT SHALL accept votes as follows.
- For each i with cast[i]=1 and voted[i]=0: set voted[i]=1 and latch yes[i]=comps[i].
- cast[i] when voted[i]=1 is ignored; the first vote is final.
REQ-019 yes_count SHALL equal popcount(yes mask) one cycle after the accepting edge.
- In COLLECT, segs shows yes_count as a decimal digit.
REQ-020 Digit encodings (segs, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; 'A'=08, 'r'=2F, '-'=3F, blank=7F.
REQ-021 The timeout counter SHALL increment on every COLLECT cycle.
REQ-022 COLLECT -> DECIDE on the first edge where any of the following holds:
- the voted mask is all ones, including votes accepted on that same edge;
- close=1;
- the timeout counter reaches TIMEOUT-1.
REQ-023 On the COLLECT -> DECIDE edge, votes presented that cycle SHALL still be accepted.
REQ-024 Simultaneous exit conditions SHALL cause a single transition.
REQ-025 DECIDE SHALL last exactly one cycle.
- segs = 0x3F ('-').
- passed <= (final yes_count >= QUORUM).
- Next state SHOW.
REQ-026 SHOW SHALL behave as follows.
- done = 1.
- segs = 0x08 if passed, else 0x2F.
- yes_count and passed held.
- After exactly HOLD cycles -> IDLE.
REQ-027 start SHALL be ignored in COLLECT, DECIDE and SHOW.
- start in the first IDLE cycle after SHOW opens a new ballot.
REQ-028 Abstainers (voted[i]=0 at close) SHALL count as no.
REQ-029 close and cast SHALL be ignored outside COLLECT.
- cast outside COLLECT does not alter the masks.

Reset
REQ-030 rst=1 SHALL immediately force the following, independent of clk:
- state IDLE;
- voted and yes masks to zero;
- yes_count=0, passed=0, busy=0, done=0;
- segs=0x7F;
- timeout counter to zero.
REQ-031 rst asserted mid-COLLECT or mid-SHOW SHALL discard the ballot with no residual outputs.
REQ-032 After rst deasserts, the block SHALL wait in IDLE for start.

Verification (N_VOTERS=5, QUORUM=3, TIMEOUT=16, HOLD=4)
REQ-033 start; cast=11111, comps=10110 in one cycle -> yes_count=3; then DECIDE and SHOW with passed=1, segs=08, done high 4 cycles, then IDLE with segs=7F.
REQ-034 start; cast=00001 comps=00001, then cast=00001 comps=00000 -> second vote ignored, yes_count stays 1; close -> passed=0, segs=2F.
REQ-035 start; no casts -> DECIDE entered after exactly 16 COLLECT cycles, yes_count=0, passed=0.
REQ-036 In COLLECT: cast=00011 comps=00011 together with close=1 -> votes counted, yes_count=2, single DECIDE cycle, passed=0.
REQ-037 rst pulse in the 2nd SHOW cycle -> asynchronous return to segs=7F, done=0, passed=0; a subsequent start begins a clean ballot with yes_count=0.
REQ-038 start held high through a full ballot -> no restart before IDLE; new COLLECT begins on the first IDLE cycle.
